// File: rtl/ei_reg_arbiter.sv
// BLE setup register bank with round-robin single-port arbitration and 1-cycle read latency.
// Optional grant locking (atomic multi-register writes) is built when EI_ARB_LOCK_EN is defined.
module ei_reg_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 44
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    input  logic [NUM_REQ-1:0]        lock
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int ERR_IDX = NUM_REGS - 1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]  bank_q [ERR_IDX];
    logic [1:0]         err_q, err_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] elig;
    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic               acc_we;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic               acc_illegal;
    logic               acc_is_err;
    logic [DATA_W-1:0]  rd_val;
    logic               lock_timeout;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_REQ - 1)
            return '0;
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        // Walk downward so the requester closest to the pointer is assigned last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    assign req_ready   = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign acc_we      = req_we[gnt_idx];
    assign acc_addr    = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign acc_wdata   = req_wdata[gnt_idx*DATA_W +: DATA_W];
    assign acc_illegal = int'(acc_addr) >= NUM_REGS;
    assign acc_is_err  = acc_addr == ADDR_W'(ERR_IDX);

    always_comb begin
        rd_val = '0;
        if (!acc_illegal) begin
            if (acc_is_err)
                rd_val = DATA_W'(err_q);
            else
                rd_val = bank_q[acc_addr];
        end
    end

    always_comb begin
        err_d = err_q;
        if (gnt_any && acc_we && acc_is_err)
            err_d = err_q & ~acc_wdata[1:0];
        // Hardware set events are applied after the clear so they win on collision.
        if (gnt_any && acc_illegal)
            err_d[0] = 1'b1;
        if (lock_timeout)
            err_d[1] = 1'b1;
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = gnt_any && acc_illegal;
        if (gnt_any && !acc_we) begin
            rsp_valid_d = req_ready;
            rsp_rdata_d = rd_val;
        end
    end

`ifdef EI_ARB_LOCK_EN
    logic             owned_q, owned_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [3:0]       idle_cnt_q, idle_cnt_d;
    logic             lock_rel;

    always_comb begin
        owned_d      = owned_q;
        owner_d      = owner_q;
        idle_cnt_d   = idle_cnt_q;
        lock_timeout = 1'b0;
        lock_rel     = 1'b0;
        if (owned_q) begin
            if (!lock[owner_q]) begin
                lock_rel = 1'b1;
            end else if (req_valid[owner_q]) begin
                idle_cnt_d = 4'd15;
            end else if (idle_cnt_q == 4'd0) begin
                lock_rel     = 1'b1;
                lock_timeout = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q - 4'd1;
            end
            if (lock_rel)
                owned_d = 1'b0;
        end else if (gnt_any && lock[gnt_idx]) begin
            owned_d    = 1'b1;
            owner_d    = gnt_idx;
            idle_cnt_d = 4'd15;
        end
    end

    assign elig = owned_q ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;

    always_comb begin
        ptr_d = ptr_q;
        if (owned_q) begin
            if (lock_rel)
                ptr_d = ptr_inc(owner_q);
        end else if (gnt_any) begin
            ptr_d = ptr_inc(gnt_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owned_q    <= 1'b0;
            owner_q    <= '0;
            idle_cnt_q <= '0;
        end else begin
            owned_q    <= owned_d;
            owner_q    <= owner_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_lock;

    assign unused_lock  = ^lock;
    assign elig         = req_valid;
    assign lock_timeout = 1'b0;
    assign ptr_d        = gnt_any ? ptr_inc(gnt_idx) : ptr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            err_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            for (int r = 0; r < ERR_IDX; r++)
                bank_q[r] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (gnt_any && acc_we && !acc_illegal && !acc_is_err)
                bank_q[acc_addr] <= acc_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ei_reg_arbiter.sv
// Self-checking bench for ei_reg_arbiter: vector table, hand-written corner sequences and a
// randomized run against a behavioural model. Lock sequences build only with EI_ARB_LOCK_EN.
module tb_ei_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid, req_we, req_ready, rsp_valid, lock;
    logic [17:0] req_addr;
    logic [23:0] req_wdata;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    ei_reg_arbiter #(.NUM_REQ(3), .ADDR_W(6), .DATA_W(8), .NUM_REGS(44)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .lock(lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  v;
        logic [2:0]  we;
        logic [17:0] addr;
        logic [23:0] wd;
        logic [2:0]  rdy;
        logic [2:0]  rv;
        logic [7:0]  rd;
        logic        err;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] we,
                         input logic [17:0] a, input logic [23:0] w);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = w;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        lock = 3'b000;
        drive(3'b000, 3'b000, 18'd0, 24'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rsp_pack(input logic [2:0] rv, input logic [7:0] rd, input logic e);
        return {20'd0, rv, rd, e};
    endfunction

    // Behavioural model state for the randomized phase
    int          m_bank[44];
    int          m_err;
    int          m_ptr;
    logic [31:0] m_rsp;
    logic        pv[3];
    logic        pwe[3];
    int          paddr[3];
    int          pwd[3];

    initial begin
        rst = 1'b1;
        lock = 3'b000;
        drive(3'b000, 3'b000, 18'd0, 24'd0);

        // {v, we, {a2,a1,a0}, {w2,w1,w0}, ready, rsp_valid, rsp_rdata, rsp_err}
        tbl[0]  = '{3'b010, 3'b010, {6'd0, 6'd30, 6'd0}, {8'h00, 8'h05, 8'h00}, 3'b010, 3'b000, 8'h00, 1'b0};
        tbl[1]  = '{3'b010, 3'b000, {6'd0, 6'd30, 6'd0}, 24'd0, 3'b010, 3'b000, 8'h00, 1'b0};
        tbl[2]  = '{3'b000, 3'b000, 18'd0, 24'd0, 3'b000, 3'b010, 8'h05, 1'b0};
        tbl[3]  = '{3'b000, 3'b000, 18'd0, 24'd0, 3'b000, 3'b000, 8'h00, 1'b0};
        tbl[4]  = '{3'b111, 3'b000, {6'd1, 6'd30, 6'd0}, 24'd0, 3'b100, 3'b000, 8'h00, 1'b0};
        tbl[5]  = '{3'b111, 3'b000, {6'd1, 6'd30, 6'd0}, 24'd0, 3'b001, 3'b100, 8'h00, 1'b0};
        tbl[6]  = '{3'b111, 3'b000, {6'd1, 6'd30, 6'd0}, 24'd0, 3'b010, 3'b001, 8'h00, 1'b0};
        tbl[7]  = '{3'b111, 3'b000, {6'd1, 6'd30, 6'd0}, 24'd0, 3'b100, 3'b010, 8'h05, 1'b0};
        tbl[8]  = '{3'b000, 3'b000, 18'd0, 24'd0, 3'b000, 3'b100, 8'h00, 1'b0};
        tbl[9]  = '{3'b001, 3'b000, {6'd0, 6'd0, 6'd50}, 24'd0, 3'b001, 3'b000, 8'h00, 1'b0};
        tbl[10] = '{3'b001, 3'b000, {6'd0, 6'd0, 6'd43}, 24'd0, 3'b001, 3'b001, 8'h00, 1'b1};
        tbl[11] = '{3'b001, 3'b001, {6'd0, 6'd0, 6'd43}, {8'h00, 8'h00, 8'h01}, 3'b001, 3'b001, 8'h01, 1'b0};
        tbl[12] = '{3'b001, 3'b000, {6'd0, 6'd0, 6'd43}, 24'd0, 3'b001, 3'b000, 8'h00, 1'b0};
        tbl[13] = '{3'b001, 3'b001, {6'd0, 6'd0, 6'd60}, {8'h00, 8'h00, 8'hAA}, 3'b001, 3'b001, 8'h00, 1'b0};
        tbl[14] = '{3'b000, 3'b000, 18'd0, 24'd0, 3'b000, 3'b000, 8'h00, 1'b1};
        tbl[15] = '{3'b100, 3'b000, {6'd43, 6'd0, 6'd0}, 24'd0, 3'b100, 3'b000, 8'h00, 1'b0};
        tbl[16] = '{3'b000, 3'b000, 18'd0, 24'd0, 3'b000, 3'b100, 8'h01, 1'b0};
        tbl[17] = '{3'b000, 3'b000, 18'd0, 24'd0, 3'b000, 3'b000, 8'h00, 1'b0};

        @(negedge clk);
        chk("reset_rsp", rsp_pack(rsp_valid, rsp_rdata, rsp_err), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].we, tbl[i].addr, tbl[i].wd);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_rsp", i), rsp_pack(rsp_valid, rsp_rdata, rsp_err),
                rsp_pack(tbl[i].rv, tbl[i].rd, tbl[i].err));
            next_cycle();
        end

        // Reset lands while a read response is in flight
        drive(3'b010, 3'b000, {6'd0, 6'd30, 6'd0}, 24'd0);
        @(negedge clk);
        chk("mid_rst_grant", 32'(req_ready), 32'b010);
        next_cycle();
        rst = 1'b1;
        drive(3'b000, 3'b000, 18'd0, 24'd0);
        @(negedge clk);
        chk("mid_rst_rsp", rsp_pack(rsp_valid, rsp_rdata, rsp_err), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp", rsp_pack(rsp_valid, rsp_rdata, rsp_err), 32'd0);
        next_cycle();
        drive(3'b011, 3'b000, {6'd0, 6'd30, 6'd30}, 24'd0);
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'b001);
        next_cycle();
        drive(3'b000, 3'b000, 18'd0, 24'd0);
        @(negedge clk);
        chk("post_rst_bank", rsp_pack(rsp_valid, rsp_rdata, rsp_err), rsp_pack(3'b001, 8'h00, 1'b0));
        next_cycle();

        // Continuous requests from reset rotate 0,1,2 with no bubbles
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(3'b111, 3'b000, {6'd2, 6'd1, 6'd0}, 24'd0);
            @(negedge clk);
            chk($sformatf("rr%0d_ready", c), 32'(req_ready), 32'(3'b001 << (c % 3)));
            next_cycle();
        end

`ifdef EI_ARB_LOCK_EN
        // Requester 2 locks and writes the device-name block while requester 0 waits
        do_reset();
        lock = 3'b100;
        drive(3'b100, 3'b100, {6'd16, 6'd0, 6'd0}, {8'd16, 8'd0, 8'd0});
        @(negedge clk);
        chk("lk_first", 32'(req_ready), 32'b100);
        next_cycle();
        for (int n = 17; n < 24; n++) begin
            drive(3'b101, 3'b100, {6'(n), 6'd0, 6'd0}, {8'(n), 8'd0, 8'd0});
            @(negedge clk);
            chk($sformatf("lk_hold%0d", n), 32'(req_ready), 32'b100);
            next_cycle();
        end
        lock = 3'b000;
        drive(3'b001, 3'b000, 18'd0, 24'd0);
        @(negedge clk);
        chk("lk_drop", 32'(req_ready), 32'b000);
        next_cycle();
        @(negedge clk);
        chk("lk_after", 32'(req_ready), 32'b001);
        next_cycle();
        drive(3'b010, 3'b000, {6'd0, 6'd20, 6'd0}, 24'd0);
        next_cycle();
        drive(3'b000, 3'b000, 18'd0, 24'd0);
        @(negedge clk);
        chk("lk_data", rsp_pack(rsp_valid, rsp_rdata, rsp_err), rsp_pack(3'b010, 8'd20, 1'b0));
        next_cycle();

        // Owner idles with lock held: released after 16 cycles and timeout flagged
        do_reset();
        lock = 3'b001;
        drive(3'b001, 3'b001, {6'd0, 6'd0, 6'd16}, {8'd0, 8'd0, 8'h33});
        @(negedge clk);
        chk("to_first", 32'(req_ready), 32'b001);
        next_cycle();
        for (int c = 0; c < 16; c++) begin
            drive(3'b010, 3'b000, {6'd0, 6'd43, 6'd0}, 24'd0);
            @(negedge clk);
            chk($sformatf("to_idle%0d", c), 32'(req_ready), 32'b000);
            next_cycle();
        end
        @(negedge clk);
        chk("to_release", 32'(req_ready), 32'b010);
        next_cycle();
        lock = 3'b000;
        drive(3'b000, 3'b000, 18'd0, 24'd0);
        @(negedge clk);
        chk("to_errreg", rsp_pack(rsp_valid, rsp_rdata, rsp_err), rsp_pack(3'b010, 8'h02, 1'b0));
        next_cycle();
`endif

        // Randomized traffic against the behavioural model
        do_reset();
        for (int r = 0; r < 44; r++) m_bank[r] = 0;
        m_err = 0;
        m_ptr = 0;
        m_rsp = 32'd0;
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int          g;
            int          sel;
            logic [2:0]  v, we;
            logic [17:0] a;
            logic [23:0] w;
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 60) begin
                    pv[i]  = 1'b1;
                    pwe[i] = 1'($urandom_range(0, 1));
                    sel    = int'($urandom_range(0, 9));
                    if (sel == 0)      paddr[i] = int'($urandom_range(44, 63));
                    else if (sel == 1) paddr[i] = 43;
                    else if (sel < 6)  paddr[i] = int'($urandom_range(0, 3));
                    else               paddr[i] = int'($urandom_range(0, 42));
                    pwd[i] = int'($urandom_range(0, 255));
                end
            end
            v = '0; we = '0; a = '0; w = '0;
            for (int i = 0; i < 3; i++) begin
                v[i]          = pv[i];
                we[i]         = pv[i] & pwe[i];
                a[i*6 +: 6]   = pv[i] ? 6'(paddr[i]) : 6'd0;
                w[i*8 +: 8]   = pv[i] ? 8'(pwd[i]) : 8'd0;
            end
            drive(v, we, a, w);
            g = -1;
            for (int k = 0; k < 3; k++)
                if (g < 0 && pv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            @(negedge clk);
            chk($sformatf("rnd%0d_ready", cyc), 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            chk($sformatf("rnd%0d_rsp", cyc), rsp_pack(rsp_valid, rsp_rdata, rsp_err), m_rsp);
            m_rsp = 32'd0;
            if (g >= 0) begin
                logic illegal;
                illegal = paddr[g] >= 44;
                if (pwe[g]) begin
                    if (illegal)           m_err = m_err | 1;
                    else if (paddr[g] == 43) m_err = m_err & ~pwd[g] & 3;
                    else                   m_bank[paddr[g]] = pwd[g];
                    m_rsp = rsp_pack(3'b000, 8'h00, illegal);
                end else begin
                    int data;
                    if (illegal)             data = 0;
                    else if (paddr[g] == 43) data = m_err;
                    else                     data = m_bank[paddr[g]];
                    if (illegal) m_err = m_err | 1;
                    m_rsp = rsp_pack(3'(1 << g), 8'(data), illegal);
                end
                m_ptr = (g + 1) % 3;
                pv[g] = 1'b0;
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ei_reg_arbiter.md
Name: ei_reg_arbiter

Overview:
- Owns the 44-entry BLE setup register bank, indexed by the ei_regs_t encoding: index 0 = EIR_TEST … 43 = EIR_ERROR.
- Arbitrates single-port access to the bank between NUM_REQ requesters, for example the UART command parser, the BLE setup sequencer and the timer block.
- Uses round-robin grant, one access per cycle and 1-cycle read latency.
- Flags illegal addresses in the EIR_ERROR register.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 6, register index width; matches ei_regs_t.
- DATA_W, 8, register width.
- NUM_REGS, 44, implemented registers; indices >= NUM_REGS are illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened register index; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_ready  out  NUM_REQ  one-hot grant; the access is accepted in the cycle where valid&ready.
- rsp_valid  out  NUM_REQ  one-hot; pulses 1 cycle after an accepted read.
- rsp_rdata  out  DATA_W  shared read data; qualified by rsp_valid.
- rsp_err  out  1  the accepted access one cycle earlier hit an illegal address; valid with rsp_valid, and also pulses for writes.
- lock  in  NUM_REQ  grant hold request (only with EI_ARB_LOCK_EN).

Behaviour:
- Reset values:
  - All bank registers = 0.
  - RR pointer = 0.
  - req_ready, rsp_valid, rsp_err = 0; rsp_rdata = 0.
- Arbitration:
  - Combinational grant: the first asserted req_valid searching from the pointer upward, with wrap-around.
  - req_ready is asserted for the winner only, and only when its req_valid is high.
  - A requester must hold valid, we, addr and wdata stable until ready.
- Pointer update: after a grant to requester i, the pointer becomes (i+1) mod NUM_REQ. With no requests, the pointer holds.
- Write:
  - Bank[addr] takes wdata at the accepting edge.
  - Exception: writes to EIR_ERROR (index 43) are write-1-to-clear per bit.
- Read:
  - Bank[addr] is sampled at the accepting edge.
  - rsp_rdata and rsp_valid[i] present the sampled value for exactly one cycle.
  - rsp_rdata returns to 0 when rsp_valid is low.
- Read-after-write to the same index in consecutive cycles returns the new data.
- Illegal address (addr >= NUM_REGS):
  - The handshake still completes.
  - No bank write occurs; read data = 0.
  - rsp_err = 1 in the next cycle.
  - EIR_ERROR bit0 (addr-fault) is set.
  - For illegal writes, rsp_valid stays 0 and rsp_err still pulses.
- EIR_ERROR bits:
  - bit0 = addr-fault.
  - bit1 = lock-timeout (feature only).
  - All other bits read 0.
  - If a hardware set and a W1C clear land on the same bit in the same cycle, the set wins.
- Throughput: one access per cycle sustained. Back-to-back grants to different requesters are allowed, so rsp_valid may be high while a new access is being accepted.
- Mid-operation reset: clears the pending response immediately; no rsp_valid is emitted after reset deasserts.
- There is no FSM beyond the pointer, the response pipeline register and the lock state.

Optional Feature:
- Macro name: EI_ARB_LOCK_EN.
- Enabled:
  - A requester granted while its lock bit is 1 becomes the owner.
  - Only the owner may be granted until it drops lock or 16 consecutive idle cycles pass (owner lock=1, valid=0). This lets it write EIR_DVC_NAME0..7 atomically.
  - On the 16-cycle timeout: ownership is released and EIR_ERROR bit1 is set.
  - While locked, the pointer is frozen. On release, the pointer becomes owner+1.
- Disabled: the lock input is ignored, no lock state exists, and EIR_ERROR bit1 reads 0.

Test Plan:
1. Requester 1 writes idx 30 (EIR_BAUD_RATE) = 0x05, then reads idx 30 the next cycle -> ready[1] both cycles; rsp_valid=3'b010 one cycle after the read, with rsp_rdata=0x05 and rsp_err=0.
2. All three requesters request reads continuously from reset -> grants go 0,1,2,0,1,2 on consecutive cycles, with no bubbles.
3. Requester 0 reads idx 50 -> rsp_valid[0]=1, rsp_rdata=0x00, rsp_err=1. A subsequent read of idx 43 returns 0x01. Writing 0x01 to idx 43 clears it, and a re-read returns 0x00.
4. rst is asserted during the cycle after an accepted read -> rsp_valid stays 0. The bank reads 0 after reset, and the next grant goes to requester 0.
5. (EI_ARB_LOCK_EN) Requester 2 locks and writes idx 16..23 while requester 0 holds valid -> requester 0 is not granted until requester 2 drops lock, then requester 0 is granted the following cycle.
6. (EI_ARB_LOCK_EN) Owner holds lock with valid=0 for 16 cycles -> the other requester is granted in the next cycle, and idx 43 reads 0x02.
